// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter sharing one FIFO write port, with bounded bursts.
// Optional per-requester beat counters enabled by FIFO_ARB_STATS_EN.
module fifo_wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int DWIDTH    = 16,
  parameter int BURST_LEN = 4
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ*DWIDTH-1:0]     din_flat,
  output logic [NREQ-1:0]            gnt,
  input  logic                       fifo_full,
  output logic                       fifo_wr_en,
  output logic [DWIDTH-1:0]          fifo_din,
  output logic                       busy,
  output logic [$clog2(NREQ)-1:0]    owner_id,
  output logic [NREQ*16-1:0]         stat_cnt
);

  localparam int IW = $clog2(NREQ);
  localparam logic [7:0] BL8 = 8'(BURST_LEN);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t        state, state_n;
  logic [IW-1:0] rr_ptr, rr_n;
  logic [IW-1:0] own_n;
  logic [7:0]    beat_cnt, beat_n;
  logic [IW-1:0] pick;
  logic          pick_vld;
  logic [NREQ-1:0] gnt_c;

  function automatic logic [IW-1:0] inc_ptr(input logic [IW-1:0] p);
    if (int'(p) == NREQ - 1) return '0;
    return p + IW'(1);
  endfunction

  // first requester at or after rr_ptr, wrapping modulo NREQ
  always_comb begin
    logic [IW:0]   sum;
    logic [IW-1:0] idx;
    sum      = '0;
    idx      = '0;
    pick_vld = 1'b0;
    pick     = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, rr_ptr} + (IW+1)'(k);
      if (sum >= (IW+1)'(NREQ)) sum = sum - (IW+1)'(NREQ);
      idx = sum[IW-1:0];
      if (!pick_vld && req[idx]) begin
        pick_vld = 1'b1;
        pick     = idx;
      end
    end
  end

  always_comb begin
    gnt_c = '0;
    unique case (state)
      IDLE: begin
        if (pick_vld && !fifo_full) gnt_c[pick] = 1'b1;
      end
      BURST: begin
        if (req[owner_id] && !fifo_full) gnt_c[owner_id] = 1'b1;
      end
      default: ;
    endcase
  end

  // reset must silence grants before any clock edge
  assign gnt        = rstn ? gnt_c : '0;
  assign fifo_wr_en = |(req & gnt);
  assign busy       = (state == BURST);

  always_comb begin
    fifo_din = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) fifo_din = fifo_din | din_flat[i*DWIDTH +: DWIDTH];
    end
  end

  always_comb begin
    state_n = state;
    rr_n    = rr_ptr;
    own_n   = owner_id;
    beat_n  = beat_cnt;
    unique case (state)
      IDLE: begin
        if (pick_vld && !fifo_full) begin
          own_n = pick;
          if (BURST_LEN == 1) begin
            rr_n = inc_ptr(pick);
          end else begin
            beat_n  = 8'd1;
            state_n = BURST;
          end
        end
      end
      BURST: begin
        if (!fifo_full) begin
          if (req[owner_id]) begin
            if (beat_cnt + 8'd1 == BL8) begin
              state_n = IDLE;
              rr_n    = inc_ptr(owner_id);
              beat_n  = '0;
            end else begin
              beat_n = beat_cnt + 8'd1;
            end
          end else begin
            state_n = IDLE;
            rr_n    = inc_ptr(owner_id);
            beat_n  = '0;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      owner_id <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_n;
      rr_ptr   <= rr_n;
      owner_id <= own_n;
      beat_cnt <= beat_n;
    end
  end

`ifdef FIFO_ARB_STATS_EN
  for (genvar i = 0; i < NREQ; i++) begin : g_stat
    logic [15:0] cnt;
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        cnt <= '0;
      end else if (req[i] && gnt[i] && cnt != 16'hFFFF) begin
        cnt <= cnt + 16'd1;
      end
    end
    assign stat_cnt[i*16 +: 16] = cnt;
  end
`else
  assign stat_cnt = '0;
`endif

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write arbiter that shares one Sync_FIFO write port among NREQ requesters.
- Drives the FIFO's wr_en/din and watches its full flag, so no write is ever issued into a full FIFO.
- Supports bounded bursts: a granted requester keeps the port for up to BURST_LEN consecutive beats before priority rotates.
- Sits between producer blocks and the FIFO write side in the same clock domain.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DWIDTH, 16, data width; must match the FIFO's DWIDTH.
- BURST_LEN, 4, maximum beats per grant tenure (1..255).

Ports:
- clk  input  1  system clock, rising edge.
- rstn  input  1  asynchronous, active-low reset.
- req  input  NREQ  per-requester write request; req[i] means din_flat slice i is valid.
- din_flat  input  NREQ*DWIDTH  requester data; slice i is bits [i*DWIDTH +: DWIDTH].
- gnt  output  NREQ  one-hot or zero; a beat transfers from i in any cycle where req[i] and gnt[i] are both 1.
- fifo_full  input  1  full flag from the FIFO.
- fifo_wr_en  output  1  FIFO write enable.
- fifo_din  output  DWIDTH  FIFO write data.
- busy  output  1  high while in the BURST state.
- owner_id  output  clog2(NREQ)  current or last burst owner.
- stat_cnt  output  NREQ*16  per-requester beat counters (see Optional Feature).

Behaviour:
- Reset: clk and rstn are the only clock/reset; rstn is asynchronous, active-low.
  - While rstn=0: state=IDLE, rr_ptr=0, owner_id=0, beat_cnt=0, stat_cnt=0.
  - gnt=0, fifo_wr_en=0 and busy=0 are forced immediately, without waiting for a clock edge.
- Grant logic is combinational from state, rr_ptr, owner_id, req and fifo_full. Zero-latency handshake: a write lands in the FIFO on the same edge as the transfer.
- fifo_wr_en = OR(req & gnt).
- fifo_din = selected requester's slice, or 0 when there is no grant.
- If fifo_full=1: gnt=0 and fifo_wr_en=0 unconditionally. State, beat_cnt and rr_ptr hold.
- IDLE state:
  - If any req and !fifo_full, grant the first requester i with req[i]=1, scanning from rr_ptr upward modulo NREQ. The beat transfers this cycle.
  - If BURST_LEN=1: rr_ptr <= i+1 mod NREQ and stay in IDLE.
  - Otherwise: owner_id <= i, beat_cnt <= 1, go to BURST.
- BURST state:
  - gnt[owner_id] = req[owner_id] & !fifo_full. All other grants are 0.
  - On a transfer, beat_cnt increments.
  - If the transfer makes beat_cnt = BURST_LEN: go to IDLE, rr_ptr <= owner_id+1 mod NREQ, beat_cnt <= 0.
  - If req[owner_id]=0: no transfer this cycle (one bubble). Go to IDLE, rr_ptr <= owner_id+1 mod NREQ.
  - A fifo_full stall does not end the burst.
- There is no idle cycle on burst expiry. Priority has already rotated when IDLE arbitrates on the next cycle.
- Requester obligations: data is held stable while req is high. Dropping req without a grant is legal and simply withdraws the request.
- beat_cnt is 8 bits, and owner_id/rr_ptr are clog2(NREQ) bits. Wrap-around is modulo NREQ, so NREQ need not be a power of two.
- Reset asserted mid-burst abandons the burst. No partial write is generated.

Optional Feature:
- Macro: FIFO_ARB_STATS_EN.
- Defined: stat_cnt slice i is a 16-bit counter that increments on every transfer from requester i. It saturates at 0xFFFF and is cleared by rstn.
- Not defined: stat_cnt is tied to 0, with no counter flops. All other behaviour is identical.

Test Plan:
(All scenarios use NREQ=4, DWIDTH=16, BURST_LEN=4.)
1. Reset hold: rstn=0 with req=4'b1111 -> gnt=0 and fifo_wr_en=0. After release, the first write is req0's data (0xA000).
2. req1 held high for 6 cycles, data 0xB001..0xB006, fifo_full=0 -> 6 back-to-back writes with no gap. busy=1 in cycles 2-4. rr_ptr=2 after beat 4.
3. req=4'b1111 continuously -> grant order 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0. fifo_wr_en is high every cycle.
4. Burst of req0; fifo_full=1 for 3 cycles after beat 2 -> gnt=0 and fifo_wr_en=0 for those 3 cycles. Beats 3-4 resume immediately after, then req1 (pending) is granted.
5. req0 drops after 2 beats while req2 is pending -> one cycle with fifo_wr_en=0, then req2 is granted. rr_ptr had moved to 1; req1 is idle.
6. rstn pulsed low mid-burst, between clock edges -> gnt and fifo_wr_en go to 0 asynchronously. With FIFO_ARB_STATS_EN defined, stat_cnt reads 0 after reset and 3 after 3 further req3 beats.
